// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
// Build option: ADDSUB_SERIAL_SAT_EN enables signed saturation in the top.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the saturation constants below can describe.
    localparam int MAX_WIDTH = 128;

    // Digit index width; a single-digit configuration still needs one bit.
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide slice of the add/subtract chain. Combinational; the chain is
// a carry for add and a borrow for sub.
module addsub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             op_sub,
    input  logic             chain_in,
    output logic [DIGIT-1:0] s_d,
    output logic             chain_out,
    output logic             chain_msb_in
);

    logic [DIGIT:0] full;

    always_comb begin
        full = '0;
        if (op_sub) begin
            full = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, chain_in};
        end else begin
            full = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, chain_in};
        end
    end

    assign s_d       = full[DIGIT-1:0];
    assign chain_out = full[DIGIT];

    // Chain entering the slice's top bit: re-run the operation on the low bits.
    if (DIGIT == 1) begin : g_one_bit
        assign chain_msb_in = chain_in;
    end else begin : g_multi_bit
        logic [DIGIT-1:0] low;
        always_comb begin
            low = '0;
            if (op_sub) begin
                low = {1'b0, a_d[DIGIT-2:0]} - {1'b0, b_d[DIGIT-2:0]}
                      - {{(DIGIT-1){1'b0}}, chain_in};
            end else begin
                low = {1'b0, a_d[DIGIT-2:0]} + {1'b0, b_d[DIGIT-2:0]}
                      + {{(DIGIT-1){1'b0}}, chain_in};
            end
        end
        assign chain_msb_in = low[DIGIT-1];
    end

endmodule

// File: rtl/addsub_digit_serial.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per cycle, LSB digit first.
// Build option: define ADDSUB_SERIAL_SAT_EN to clamp on signed overflow when sat=1.
module addsub_digit_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic [1:0]       dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = idx_width(NDIG);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0) || (WIDTH > MAX_WIDTH))
    begin : g_bad_cfg
        $error("addsub_digit_serial: illegal WIDTH/DIGIT combination");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready and out_valid come straight from the state register.
    state_t state, state_nx;
    logic   accept, step, last;

    logic [WIDTH-1:0] a_r, b_r;
    logic             op_r;
    logic             chain_r;
    logic [IDXW-1:0]  idx;

    logic [DIGIT-1:0] a_d, b_d, s_d;
    logic             chain_out, chain_msb_in;
    logic [WIDTH-1:0] res_nx, fin;
    logic             v_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // One slice adder, fed by a digit mux over the latched operands.
    assign a_d = a_r[int'(idx)*DIGIT +: DIGIT];
    assign b_d = b_r[int'(idx)*DIGIT +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d          (a_d),
        .b_d          (b_d),
        .op_sub       (op_r),
        .chain_in     (chain_r),
        .s_d          (s_d),
        .chain_out    (chain_out),
        .chain_msb_in (chain_msb_in)
    );

    assign v_nx = chain_msb_in ^ chain_out;

    always_comb begin
        res_nx = result;
        res_nx[int'(idx)*DIGIT +: DIGIT] = s_d;
    end

`ifdef ADDSUB_SERIAL_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
    logic sat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (accept) begin
            sat_r <= sat;
        end
    end

    // Clamp direction follows the sign of a: overflow always moves away from it.
    always_comb begin
        fin = res_nx;
        if (sat_r && v_nx) begin
            fin = a_r[WIDTH-1] ? SMIN : SMAX;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign fin        = res_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 1'b0;
            chain_r <= 1'b0;
            idx     <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            v       <= 1'b0;
            z       <= 1'b0;
            n       <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op_sub;
            chain_r <= c_in;
            idx     <= '0;
        end else if (step) begin
            chain_r <= chain_out;
            idx     <= idx + IDXW'(1);
            if (last) begin
                result <= fin;
                c_out  <= chain_out;
                v      <= v_nx;
                z      <= (fin == '0);
                n      <= fin[WIDTH-1];
            end else begin
                result <= res_nx;
            end
        end
    end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Randomised and directed bench for addsub_digit_serial against an
// arithmetic reference model (WIDTH=32, DIGIT=8).
module tb_addsub_digit_serial;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int W     = WIDTH + 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             v;
    logic             z;
    logic             n;
    logic [1:0]       dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    addsub_digit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .sat       (sat),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .v         (v),
        .z         (z),
        .n         (n),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic logic [W-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic msub, input logic msat, input logic mcin);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] r;
        logic             co, ov;
        if (!msub) begin
            full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
            co   = full[WIDTH];
            ov   = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        end else begin
            full = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mcin};
            co   = ({1'b0, ma} < ({1'b0, mb} + {{WIDTH{1'b0}}, mcin}));
            ov   = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        end
        r = full[WIDTH-1:0];
`ifdef ADDSUB_SERIAL_SAT_EN
        if (msat && ov) r = ma[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        if (msat && 1'b0) r = '0;
`endif
        return {r, co, ov, (r == '0), r[WIDTH-1]};
    endfunction

    // Scoreboard compare: every cycle the result is presented
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                check("result_flags", 64'({result, c_out, v, z, n}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: issue one op; hold<0 means out_ready is already high during RUN.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tsub, input logic tsat, input logic tcin,
                          input int hold, input bit pulse);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b1; a = ta; b = tb; op_sub = tsub; sat = tsat; c_in = tcin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op_sub = 1'($urandom); c_in = 1'($urandom);
        exp_q.push_back(model(ta, tb, tsub, tsat, tcin));
        if (hold < 0) out_ready = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(NDIG));
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("in_ready_in_done", 64'(in_ready), 64'(0));
            check("out_valid_held", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", 64'(out_valid), 64'(0));
        check("in_ready_after_consume", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(WIDTH-1){1'b1}}};
            3: return {1'b1, {(WIDTH-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_sub = 1'b0; sat = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({result, c_out, v, z, n}), 64'(0));
        rst_n = 1'b1;

        // Hand-computed pins on the reference model
        check("pin_add_ovf", 64'(model(32'h7FFF_FFFF, 32'h1, 0, 0, 0)), 64'({32'h8000_0000, 4'b0101}));
        check("pin_sub_wrap", 64'(model(32'h0, 32'h1, 1, 0, 0)), 64'({32'hFFFF_FFFF, 4'b1001}));
        check("pin_sub_zero", 64'(model(32'h5, 32'h5, 1, 0, 0)), 64'({32'h0, 4'b0010}));
        check("pin_sub_bin", 64'(model(32'h5, 32'h5, 1, 0, 1)), 64'({32'hFFFF_FFFF, 4'b1001}));
        check("pin_add_carry", 64'(model(32'hFFFF_FFFF, 32'h1, 0, 0, 0)), 64'({32'h0, 4'b1010}));
        check("pin_add_small", 64'(model(32'h3, 32'h4, 0, 0, 0)), 64'({32'h7, 4'b0000}));
`ifdef ADDSUB_SERIAL_SAT_EN
        check("pin_sat", 64'(model(32'h8000_0000, 32'h1, 1, 1, 0)), 64'({32'h8000_0000, 4'b0101}));
`else
        check("pin_sat", 64'(model(32'h8000_0000, 32'h1, 1, 1, 0)), 64'({32'h7FFF_FFFF, 4'b0100}));
`endif

        // Directed cases
        run_op(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
        run_op(32'h0, 32'h1, 1, 0, 0, -1, 0);
        run_op(32'h5, 32'h5, 1, 0, 0, 1, 0);
        run_op(32'h5, 32'h5, 1, 0, 1, 0, 0);
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1, 5, 1);
        run_op(32'h8000_0000, 32'h1, 1, 1, 0, 0, 0);

        // Reset while digit 2 is being computed
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0FED_CBA9; op_sub = 1'b0; c_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_outputs", 64'({result, c_out, v, z, n}), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(32'h3, 32'h4, 0, 0, 0, 0, 0);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 4)) - 1, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
